// File: rtl/writeback_arbiter_if.sv
// Bundles the writeback arbiter's source-side and core-side handshake signals.
// Latency: none (wiring only).
// Backpressure: carried by core_writeback_arbiter_ready; sources see it via their acknowledge.
interface writeback_arbiter_if #(
  parameter int NUM_SOURCES = 3,
  parameter int DATA_WIDTH  = 64,
  parameter int PASS_WIDTH  = 16
);
  localparam int DW = DATA_WIDTH + PASS_WIDTH;

  logic                       flush;
  logic [NUM_SOURCES-1:0]     source_writeback_arbiter_valid;
  logic [NUM_SOURCES-1:0]     writeback_arbiter_source_acknowledge;
  logic [NUM_SOURCES*DW-1:0]  source_writeback_arbiter_data;
  logic                       writeback_arbiter_core_valid;
  logic                       core_writeback_arbiter_ready;
  logic [DW-1:0]              writeback_arbiter_core_data;
  logic                       writeback_arbiter_busy;

  // Arbiter side: drives acknowledges, the core result and busy.
  modport master (
    input  flush,
    input  source_writeback_arbiter_valid,
    input  source_writeback_arbiter_data,
    input  core_writeback_arbiter_ready,
    output writeback_arbiter_source_acknowledge,
    output writeback_arbiter_core_valid,
    output writeback_arbiter_core_data,
    output writeback_arbiter_busy
  );

  // Environment side: the sources, the core and the flush control.
  modport slave (
    output flush,
    output source_writeback_arbiter_valid,
    output source_writeback_arbiter_data,
    output core_writeback_arbiter_ready,
    input  writeback_arbiter_source_acknowledge,
    input  writeback_arbiter_core_valid,
    input  writeback_arbiter_core_data,
    input  writeback_arbiter_busy
  );
endinterface

// File: rtl/writeback_arbiter.sv
// Round-robin arbiter sharing the messaging-unit writeback port among NUM_SOURCES producers.
// Latency: a request acknowledged in cycle N is presented to the core in cycle N+1.
// Backpressure: one-entry output register; no acknowledge while it is full and the core is not ready.
module writeback_arbiter #(
  parameter int NUM_SOURCES = 3,
  parameter int DATA_WIDTH  = 64,
  parameter int PASS_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  writeback_arbiter_if.master  bus
);
  localparam int DW    = DATA_WIDTH + PASS_WIDTH;
  localparam int PTR_W = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_SOURCES - 1);

  logic [PTR_W-1:0]       ptr;
  logic [PTR_W-1:0]       grant_idx;
  logic [PTR_W-1:0]       next_ptr;
  logic [PTR_W-1:0]       cand;
  logic                   grant_vld;
  logic                   slot_free;
  logic                   out_valid;
  logic [DW-1:0]          out_data;
  logic [NUM_SOURCES-1:0] src_valid;
  logic [NUM_SOURCES-1:0] ack;
  logic [DW-1:0]          src_slice [NUM_SOURCES];
  int                     scan_pos;

  assign src_valid = bus.source_writeback_arbiter_valid;

  for (genvar i = 0; i < NUM_SOURCES; i++) begin : g_slice
    assign src_slice[i] = bus.source_writeback_arbiter_data[i*DW +: DW];
  end

  // The register can take a new result if empty or being drained this cycle.
  assign slot_free = !out_valid || bus.core_writeback_arbiter_ready;

  // Round-robin scan starting at ptr; the index wraps by subtraction so any source count works.
  // Grants are suppressed while in reset so no source deallocates a result that would be lost.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    scan_pos  = 0;
    ack       = '0;
    if (rst_n && slot_free && !bus.flush) begin
      for (int k = 0; k < NUM_SOURCES; k++) begin
        scan_pos = int'(ptr) + k;
        if (scan_pos >= NUM_SOURCES) begin
          scan_pos = scan_pos - NUM_SOURCES;
        end
        cand = PTR_W'(scan_pos);
        if (!grant_vld && src_valid[cand]) begin
          grant_vld = 1'b1;
          grant_idx = cand;
        end
      end
    end
    if (grant_vld) begin
      ack[grant_idx] = 1'b1;
    end
  end

  // Pointer moves to the slot just after the winner, wrapping at the last source.
  assign next_ptr = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;

  // Output register and priority pointer; flush wins, then refill, then plain drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      ptr       <= '0;
    end else if (bus.flush) begin
      out_valid <= 1'b0;
    end else if (grant_vld) begin
      out_valid <= 1'b1;
      out_data  <= src_slice[grant_idx];
      ptr       <= next_ptr;
    end else if (bus.core_writeback_arbiter_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign bus.writeback_arbiter_source_acknowledge = ack;
  assign bus.writeback_arbiter_core_valid         = out_valid;
  assign bus.writeback_arbiter_core_data          = out_data;
  assign bus.writeback_arbiter_busy               = rst_n && (out_valid || (|src_valid));

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: directed scenarios plus randomized traffic.
// Latency: checks comb outputs each cycle on the falling edge against a queue-free reference model.
// Backpressure: exercised through randomized and directed core ready patterns.
module tb_writeback_arbiter;
  localparam int N  = 3;
  localparam int DW = 80;

  logic clk;
  logic rst_n;
  logic [N-1:0]  src_vld;
  logic [DW-1:0] src_dat [N];
  logic          rdy;
  logic          flsh;

  int errors = 0;
  int checks = 0;

  // Reference model: last winner index, held result.
  int            m_last;
  bit            m_vld;
  logic [DW-1:0] m_dat;

  logic [N-1:0]  obs_ack;
  logic          obs_vld;
  logic [DW-1:0] obs_dat;
  logic [N-1:0]  exp_ack;
  logic [N-1:0]  ack_seq [5];
  logic [DW-1:0] dat_seq [5];

  writeback_arbiter_if #(.NUM_SOURCES(N), .DATA_WIDTH(64), .PASS_WIDTH(16)) bus ();

  writeback_arbiter #(.NUM_SOURCES(N), .DATA_WIDTH(64), .PASS_WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.flush                          = flsh;
  assign bus.source_writeback_arbiter_valid = src_vld;
  assign bus.source_writeback_arbiter_data  = {src_dat[2], src_dat[1], src_dat[0]};
  assign bus.core_writeback_arbiter_ready   = rdy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_vld  = 1'b0;
    m_dat  = '0;
    m_last = N - 1;
  endtask

  // Winner = first requesting source after the previous winner, if the slot can take it.
  function automatic int exp_grant();
    int idx;
    if (!rst_n || flsh || (m_vld && !rdy)) return -1;
    for (int k = 1; k <= N; k++) begin
      idx = (m_last + k) % N;
      if (src_vld[idx]) return idx;
    end
    return -1;
  endfunction

  // One clock: compare on the falling edge, advance the model on the rising edge.
  task automatic tick();
    int g;
    @(negedge clk);
    g = exp_grant();
    exp_ack = (g < 0) ? '0 : (3'b001 << g);
    obs_ack = bus.writeback_arbiter_source_acknowledge;
    obs_vld = bus.writeback_arbiter_core_valid;
    obs_dat = bus.writeback_arbiter_core_data;
    chk("model_ack", DW'(obs_ack), DW'(exp_ack));
    chk("model_valid", DW'(obs_vld), DW'(m_vld));
    chk("model_data", obs_dat, m_dat);
    chk("model_busy", DW'(bus.writeback_arbiter_busy), DW'(rst_n && (m_vld || (|src_vld))));
    @(posedge clk);
    if (rst_n) begin
      if (flsh) begin
        m_vld = 1'b0;
      end else if (g >= 0) begin
        m_vld  = 1'b1;
        m_dat  = src_dat[g];
        m_last = g;
      end else if (rdy) begin
        m_vld = 1'b0;
      end
    end
    #1;
  endtask

  task automatic drop_acked();
    src_vld = src_vld & ~obs_ack;
  endtask

  initial begin
    logic [31:0] r0, r1, r2;

    // Reset with sources 0 and 2 requesting.
    rst_n = 1'b0;
    flsh  = 1'b0;
    rdy   = 1'b1;
    src_vld = 3'b101;
    src_dat[0] = {16'h1000, 64'h0000_0000_0000_A000};
    src_dat[1] = {16'h1001, 64'h0000_0000_0000_A001};
    src_dat[2] = {16'h1002, 64'h0000_0000_0000_A002};
    model_reset();
    #2;
    chk("reset_ack", DW'(bus.writeback_arbiter_source_acknowledge), DW'(3'b000));
    chk("reset_core_valid", DW'(bus.writeback_arbiter_core_valid), DW'(1'b0));
    chk("reset_busy", DW'(bus.writeback_arbiter_busy), DW'(1'b0));
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_reset_ack1", DW'(obs_ack), DW'(3'b001));
    drop_acked();
    tick();
    chk("post_reset_ack2", DW'(obs_ack), DW'(3'b100));
    chk("post_reset_valid", DW'(obs_vld), DW'(1'b1));
    chk("post_reset_data", obs_dat, src_dat[0]);
    drop_acked();
    tick();
    tick();

    // All sources continuously valid, core always ready.
    src_vld = 3'b111;
    for (int i = 0; i < 4; i++) begin
      tick();
      ack_seq[i] = obs_ack;
      dat_seq[i] = obs_dat;
    end
    src_vld = 3'b000;
    tick();
    dat_seq[4] = obs_dat;
    chk("rr_ack0", DW'(ack_seq[0]), DW'(3'b001));
    chk("rr_ack1", DW'(ack_seq[1]), DW'(3'b010));
    chk("rr_ack2", DW'(ack_seq[2]), DW'(3'b100));
    chk("rr_ack3", DW'(ack_seq[3]), DW'(3'b001));
    chk("rr_dat1", dat_seq[1], src_dat[0]);
    chk("rr_dat2", dat_seq[2], src_dat[1]);
    chk("rr_dat3", dat_seq[3], src_dat[2]);
    chk("rr_dat4", dat_seq[4], src_dat[0]);
    tick();

    // Backpressure: source 1 held for four cycles, source 2 waits.
    src_dat[1] = {16'h0042, 64'h0000_0000_0000_DEAD};
    src_dat[2] = {16'h0077, 64'h0000_0000_0000_BEEF};
    src_vld = 3'b010;
    rdy = 1'b0;
    tick();
    chk("bp_first_ack", DW'(obs_ack), DW'(3'b010));
    drop_acked();
    src_vld[2] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_hold_ack", DW'(obs_ack), DW'(3'b000));
      chk("bp_hold_data", obs_dat, {16'h0042, 64'h0000_0000_0000_DEAD});
    end
    rdy = 1'b1;
    tick();
    chk("bp_release_ack", DW'(obs_ack), DW'(3'b100));
    chk("bp_release_data", obs_dat, {16'h0042, 64'h0000_0000_0000_DEAD});
    drop_acked();
    tick();
    chk("bp_replaced_data", obs_dat, {16'h0077, 64'h0000_0000_0000_BEEF});
    tick();

    // Flush with a held result and source 0 requesting.
    rdy = 1'b0;
    src_vld = 3'b010;
    tick();
    drop_acked();
    src_vld = 3'b001;
    flsh = 1'b1;
    tick();
    chk("flush_ack", DW'(obs_ack), DW'(3'b000));
    chk("flush_valid_before", DW'(obs_vld), DW'(1'b1));
    flsh = 1'b0;
    tick();
    chk("flush_valid_after", DW'(obs_vld), DW'(1'b0));
    chk("flush_rearb_ack", DW'(obs_ack), DW'(3'b001));
    drop_acked();
    rdy = 1'b1;
    tick();

    // Wrap-around from index 2 back to index 0.
    src_vld = 3'b100;
    tick();
    chk("wrap_ack2", DW'(obs_ack), DW'(3'b100));
    drop_acked();
    src_vld = 3'b101;
    tick();
    chk("wrap_ack0", DW'(obs_ack), DW'(3'b001));
    drop_acked();
    tick();
    drop_acked();
    tick();

    // Randomized traffic: persistent requests, occasional drops, random ready and flush.
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (obs_ack[i] || (src_vld[i] && $urandom_range(15) == 0)) src_vld[i] = 1'b0;
        if (!src_vld[i] && $urandom_range(1) == 1) begin
          r0 = $urandom();
          r1 = $urandom();
          r2 = $urandom();
          src_vld[i] = 1'b1;
          src_dat[i] = {r2[15:0], r1, r0};
        end
      end
      rdy  = ($urandom_range(3) != 0);
      flsh = ($urandom_range(15) == 0);
      tick();
    end

    // Asynchronous reset while the output register is full.
    flsh = 1'b0;
    rdy = 1'b0;
    src_vld = 3'b111;
    tick();
    tick();
    chk("pre_async_valid", DW'(obs_vld), DW'(1'b1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid", DW'(bus.writeback_arbiter_core_valid), DW'(1'b0));
    chk("async_ack", DW'(bus.writeback_arbiter_source_acknowledge), DW'(3'b000));
    model_reset();
    tick();
    rst_n = 1'b1;
    rdy = 1'b1;
    tick();
    chk("restart_ack", DW'(obs_ack), DW'(3'b001));
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
